// File: rtl/reservation_station_bank.sv
// Reservation-station bank: holds decoded instructions until all three operands
// are captured from the result buses, then issues the oldest ready one.
module reservation_station_bank #(
  parameter int NUM_ENTRIES = 4,
  parameter int ROBsize     = 16,
  parameter int ROBsizeLog  = $clog2(ROBsize + 1),
  parameter int DATA_W      = 64,
  parameter int CMD_W       = 10,
  parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  needToRestore_i,
  input  logic                  decodeWriteEn_i,
  input  logic [ROBsizeLog-1:0] decodeROBTag_i,
  input  logic [ROBsizeLog-1:0] decodeROBTag1_i,
  input  logic [ROBsizeLog-1:0] decodeROBTag2_i,
  input  logic [ROBsizeLog-1:0] decodeROBTag3_i,
  input  logic [DATA_W:0]       decodeROBval1_i,
  input  logic [DATA_W:0]       decodeROBval2_i,
  input  logic [DATA_W:0]       decodeROBval3_i,
  input  logic [CMD_W-1:0]      decodeCommands_i,
  input  logic [ROBsizeLog-1:0] issueROBTagCom_i,
  input  logic [DATA_W:0]       issueROBvalCom_i,
  input  logic [ROBsizeLog-1:0] issueROBTagExec_i,
  input  logic [DATA_W:0]       issueROBvalExec_i,
  input  logic                  issueROBMemAccessExec_i,
  input  logic [ROBsizeLog-1:0] issueROBTagMem_i,
  input  logic [DATA_W:0]       issueROBvalMem_i,
  input  logic                  stall_i,
  output logic                  stall_o,
  output logic [CNT_W-1:0]      freeCount_o,
  output logic                  ready_o,
  output logic [DATA_W-1:0]     reservationStationVal1_o,
  output logic [DATA_W-1:0]     reservationStationVal2_o,
  output logic [DATA_W-1:0]     reservationStationVal3_o,
  output logic [CMD_W-1:0]      reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o
);

  localparam int N  = NUM_ENTRIES;
  localparam int TW = ROBsizeLog;

  logic [N-1:0]        busy_q, busy_d;
  logic [N-1:0]        older_q [N];
  logic [N-1:0]        older_d [N];
  logic [2:0]          vld_q [N];
  logic [2:0]          vld_d [N];
  logic [TW-1:0]       tag_q [N][3];
  logic [TW-1:0]       tag_d [N][3];
  logic [DATA_W-1:0]   val_q [N][3];
  logic [DATA_W-1:0]   val_d [N][3];
  logic [CMD_W-1:0]    cmd_q [N];
  logic [CMD_W-1:0]    cmd_d [N];
  logic [TW-1:0]       dst_q [N];
  logic [TW-1:0]       dst_d [N];

  logic [N-1:0]        ready_s, blocked_s, sel_s, alloc_oh_s;
  logic                alloc_en_s, issue_en_s;
  logic [CNT_W-1:0]    free_cnt_s;
  logic [TW-1:0]       dec_tag_s [3];
  logic [DATA_W:0]     dec_val_s [3];
  logic [DATA_W:0]     dec_hit_s [3];
  logic [DATA_W:0]     ent_hit_s [N][3];

  // Returns {1, value} of the highest-priority bus carrying tag (Exec > Mem > Com), else 0.
  function automatic logic [DATA_W:0] bus_lookup(input logic [TW-1:0] tag);
    logic [DATA_W:0] r;
    if (issueROBvalExec_i[DATA_W] && !issueROBMemAccessExec_i && issueROBTagExec_i == tag)
      r = issueROBvalExec_i;
    else if (issueROBvalMem_i[DATA_W] && issueROBTagMem_i == tag)
      r = issueROBvalMem_i;
    else if (issueROBvalCom_i[DATA_W] && issueROBTagCom_i == tag)
      r = issueROBvalCom_i;
    else
      r = '0;
    return r;
  endfunction

  assign dec_tag_s[0] = decodeROBTag1_i;
  assign dec_tag_s[1] = decodeROBTag2_i;
  assign dec_tag_s[2] = decodeROBTag3_i;
  assign dec_val_s[0] = decodeROBval1_i;
  assign dec_val_s[1] = decodeROBval2_i;
  assign dec_val_s[2] = decodeROBval3_i;

  // Bus lookups for every stored operand and for the operands being decoded.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        ent_hit_s[i][k] = bus_lookup(tag_q[i][k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      dec_hit_s[k] = bus_lookup(dec_tag_s[k]);
    end
  end

  // Readiness, oldest-ready selection, lowest free slot and free count.
  always_comb begin
    ready_s    = '0;
    blocked_s  = '0;
    sel_s      = '0;
    alloc_oh_s = '0;
    free_cnt_s = '0;
    for (int i = 0; i < N; i++) begin
      ready_s[i] = busy_q[i] & (&vld_q[i]);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        blocked_s[i] = blocked_s[i] | (ready_s[j] & older_q[j][i]);
      end
      sel_s[i] = ready_s[i] & ~blocked_s[i];
    end
    // Scanning downwards leaves the lowest free index in the vector.
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_oh_s = N'(1) << i;
      else            alloc_oh_s = alloc_oh_s;
    end
    for (int i = 0; i < N; i++) begin
      free_cnt_s = free_cnt_s + CNT_W'(!busy_q[i]);
    end
  end

  assign stall_o     = &busy_q;
  assign freeCount_o = free_cnt_s;
  assign ready_o     = |ready_s;
  assign issue_en_s  = ready_o & ~stall_i;
  assign alloc_en_s  = decodeWriteEn_i & ~stall_o;

  // Next state: capture, allocation, issue, then flush overrides.
  always_comb begin
    busy_d  = busy_q;
    older_d = older_q;
    vld_d   = vld_q;
    tag_d   = tag_q;
    val_d   = val_q;
    cmd_d   = cmd_q;
    dst_d   = dst_q;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (busy_q[i] && !vld_q[i][k] && ent_hit_s[i][k][DATA_W]) begin
          vld_d[i][k] = 1'b1;
          val_d[i][k] = ent_hit_s[i][k][DATA_W-1:0];
        end else begin
          vld_d[i][k] = vld_d[i][k];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (alloc_en_s && alloc_oh_s[i]) begin
        busy_d[i]  = 1'b1;
        cmd_d[i]   = decodeCommands_i;
        dst_d[i]   = decodeROBTag_i;
        older_d[i] = '0;
        for (int k = 0; k < 3; k++) begin
          tag_d[i][k] = dec_tag_s[k];
          if (dec_val_s[k][DATA_W]) begin
            vld_d[i][k] = 1'b1;
            val_d[i][k] = dec_val_s[k][DATA_W-1:0];
          end else begin
            vld_d[i][k] = dec_hit_s[k][DATA_W];
            val_d[i][k] = dec_hit_s[k][DATA_W-1:0];
          end
        end
        for (int j = 0; j < N; j++) begin
          older_d[j][i] = busy_q[j];
        end
      end else begin
        busy_d[i] = busy_d[i];
      end
    end
    // Issue clears after allocation so a leaving entry does not stay "older".
    for (int i = 0; i < N; i++) begin
      if (issue_en_s && sel_s[i]) begin
        busy_d[i]  = 1'b0;
        older_d[i] = '0;
        for (int j = 0; j < N; j++) begin
          older_d[j][i] = 1'b0;
        end
      end else begin
        busy_d[i] = busy_d[i];
      end
    end
    if (needToRestore_i) begin
      busy_d = '0;
      for (int i = 0; i < N; i++) begin
        older_d[i] = '0;
      end
    end else begin
      busy_d = busy_d;
    end
  end

  // Issue mux: OR of the selected entry, all zeros when nothing is selected.
  always_comb begin
    reservationStationVal1_o     = '0;
    reservationStationVal2_o     = '0;
    reservationStationVal3_o     = '0;
    reservationStationCommands_o = '0;
    reservationStationTag_o      = '0;
    for (int i = 0; i < N; i++) begin
      reservationStationVal1_o     = reservationStationVal1_o | (val_q[i][0] & {DATA_W{sel_s[i]}});
      reservationStationVal2_o     = reservationStationVal2_o | (val_q[i][1] & {DATA_W{sel_s[i]}});
      reservationStationVal3_o     = reservationStationVal3_o | (val_q[i][2] & {DATA_W{sel_s[i]}});
      reservationStationCommands_o = reservationStationCommands_o | (cmd_q[i] & {CMD_W{sel_s[i]}});
      reservationStationTag_o      = reservationStationTag_o | (dst_q[i] & {TW{sel_s[i]}});
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= '0;
      for (int i = 0; i < N; i++) begin
        older_q[i] <= '0;
        vld_q[i]   <= '0;
        cmd_q[i]   <= '0;
        dst_q[i]   <= '0;
        for (int k = 0; k < 3; k++) begin
          tag_q[i][k] <= '0;
          val_q[i][k] <= '0;
        end
      end
    end else begin
      busy_q  <= busy_d;
      older_q <= older_d;
      vld_q   <= vld_d;
      tag_q   <= tag_d;
      val_q   <= val_d;
      cmd_q   <= cmd_d;
      dst_q   <= dst_d;
    end
  end

endmodule

// File: tb/tb_reservation_station_bank.sv
// Table-driven bench for reservation_station_bank (4 entries, 64-bit data):
// per-cycle vectors with hand-computed expectations plus a three-operand sequence.
module tb_reservation_station_bank;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int TW   = 5;
  localparam int CW   = 10;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            reset_i, needToRestore_i, decodeWriteEn_i, stall_i;
  logic [TW-1:0]   decodeROBTag_i, decodeROBTag1_i, decodeROBTag2_i, decodeROBTag3_i;
  logic [DW:0]     decodeROBval1_i, decodeROBval2_i, decodeROBval3_i;
  logic [CW-1:0]   decodeCommands_i;
  logic [TW-1:0]   issueROBTagCom_i, issueROBTagExec_i, issueROBTagMem_i;
  logic [DW:0]     issueROBvalCom_i, issueROBvalExec_i, issueROBvalMem_i;
  logic            issueROBMemAccessExec_i;
  logic            stall_o, ready_o;
  logic [CNTW-1:0] freeCount_o;
  logic [DW-1:0]   val1_o, val2_o, val3_o;
  logic [CW-1:0]   cmd_o;
  logic [TW-1:0]   tag_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reservation_station_bank dut (
    .clk_i(clk), .reset_i(reset_i), .needToRestore_i(needToRestore_i),
    .decodeWriteEn_i(decodeWriteEn_i), .decodeROBTag_i(decodeROBTag_i),
    .decodeROBTag1_i(decodeROBTag1_i), .decodeROBTag2_i(decodeROBTag2_i),
    .decodeROBTag3_i(decodeROBTag3_i), .decodeROBval1_i(decodeROBval1_i),
    .decodeROBval2_i(decodeROBval2_i), .decodeROBval3_i(decodeROBval3_i),
    .decodeCommands_i(decodeCommands_i),
    .issueROBTagCom_i(issueROBTagCom_i), .issueROBvalCom_i(issueROBvalCom_i),
    .issueROBTagExec_i(issueROBTagExec_i), .issueROBvalExec_i(issueROBvalExec_i),
    .issueROBMemAccessExec_i(issueROBMemAccessExec_i),
    .issueROBTagMem_i(issueROBTagMem_i), .issueROBvalMem_i(issueROBvalMem_i),
    .stall_i(stall_i), .stall_o(stall_o), .freeCount_o(freeCount_o), .ready_o(ready_o),
    .reservationStationVal1_o(val1_o), .reservationStationVal2_o(val2_o),
    .reservationStationVal3_o(val3_o), .reservationStationCommands_o(cmd_o),
    .reservationStationTag_o(tag_o)
  );

  typedef struct {
    bit            chk, rst, flush, stall, we, exe_mem;
    logic [TW-1:0] dtag, t1, com_t, exe_t, mem_t;
    logic [DW:0]   v1, com_v, exe_v, mem_v;
    bit            e_ready, e_stall;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_val1;
    logic [CNTW-1:0] e_free;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t dv(int chk, int rst, int fl, int st, int we, int dtag, int t1,
                              int v1ok, logic [DW-1:0] v1, int er, int et,
                              logic [DW-1:0] ev, int es, int ef);
    vec_t r;
    r.chk = (chk != 0); r.rst = (rst != 0); r.flush = (fl != 0);
    r.stall = (st != 0); r.we = (we != 0); r.exe_mem = 1'b0;
    r.dtag = TW'(dtag); r.t1 = TW'(t1);
    r.v1 = {(v1ok != 0), v1};
    r.com_t = '0; r.exe_t = '0; r.mem_t = '0;
    r.com_v = '0; r.exe_v = '0; r.mem_v = '0;
    r.e_ready = (er != 0); r.e_tag = TW'(et); r.e_val1 = ev;
    r.e_stall = (es != 0); r.e_free = CNTW'(ef);
    return r;
  endfunction

  // which: 0 commit, 1 execute, 2 memory
  function automatic vec_t bus(vec_t r, int which, int tag, logic [DW-1:0] val, int memacc);
    vec_t o = r;
    if (which == 0) begin o.com_t = TW'(tag); o.com_v = {1'b1, val}; end
    else if (which == 1) begin o.exe_t = TW'(tag); o.exe_v = {1'b1, val}; o.exe_mem = (memacc != 0); end
    else begin o.mem_t = TW'(tag); o.mem_v = {1'b1, val}; end
    return o;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t r);
    reset_i = r.rst; needToRestore_i = r.flush; stall_i = r.stall;
    decodeWriteEn_i = r.we; decodeROBTag_i = r.dtag;
    decodeROBTag1_i = r.t1; decodeROBval1_i = r.v1;
    decodeROBTag2_i = '0; decodeROBval2_i = {1'b1, 64'h0};
    decodeROBTag3_i = '0; decodeROBval3_i = {1'b1, 64'h0};
    decodeCommands_i = CW'(r.dtag) + 10'd100;
    issueROBTagCom_i = r.com_t; issueROBvalCom_i = r.com_v;
    issueROBTagExec_i = r.exe_t; issueROBvalExec_i = r.exe_v;
    issueROBMemAccessExec_i = r.exe_mem;
    issueROBTagMem_i = r.mem_t; issueROBvalMem_i = r.mem_v;
  endtask

  task automatic check_vec(vec_t r, int n);
    logic [CW-1:0] ecmd;
    ecmd = r.e_ready ? (CW'(r.e_tag) + 10'd100) : 10'd0;
    check($sformatf("v%0d.ready", n), 64'(ready_o), 64'(r.e_ready));
    check($sformatf("v%0d.tag", n), 64'(tag_o), 64'(r.e_tag));
    check($sformatf("v%0d.val1", n), val1_o, r.e_val1);
    check($sformatf("v%0d.cmd", n), 64'(cmd_o), 64'(ecmd));
    check($sformatf("v%0d.stall_o", n), 64'(stall_o), 64'(r.e_stall));
    check($sformatf("v%0d.free", n), 64'(freeCount_o), 64'(r.e_free));
  endtask

  initial begin
    // reset, then fill under stall_i with a dropped fifth write, then drain in order
    vecs.push_back(dv(0,1,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,1,1,  3,0,1,64'h30,  0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,1,1,  6,0,1,64'h60,  1,3,64'h30,0,3));
    vecs.push_back(dv(1,0,0,1,1,  9,0,1,64'h90,  1,3,64'h30,0,2));
    vecs.push_back(dv(1,0,0,1,1, 12,0,1,64'hC0,  1,3,64'h30,0,1));
    vecs.push_back(dv(1,0,0,1,1, 13,0,1,64'hD0,  1,3,64'h30,1,0));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,3,64'h30,1,0));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,6,64'h60,0,1));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,9,64'h90,0,2));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,12,64'hC0,0,3));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    // out-of-order wakeup: tag 5 waits on source 1, tag 6 ready
    vecs.push_back(dv(1,0,0,1,1,  5,1,0,64'h0,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,1,1,  6,0,1,64'h66,  0,0,64'h0,0,3));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,6,64'h66,0,2));
    vecs.push_back(bus(dv(1,0,0,0,0, 0,0,0,64'h0, 0,0,64'h0,0,3), 0, 1, 64'hA0, 0));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,5,64'hA0,0,3));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    // age vs index: entry 0 freed then reused must issue last; write while full dropped
    vecs.push_back(dv(1,0,0,1,1,  1,0,1,64'h10,  0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,1,1,  2,0,1,64'h20,  1,1,64'h10,0,3));
    vecs.push_back(dv(1,0,0,1,1,  3,0,1,64'h30,  1,1,64'h10,0,2));
    vecs.push_back(dv(1,0,0,1,1,  4,0,1,64'h40,  1,1,64'h10,0,1));
    vecs.push_back(dv(1,0,0,0,1,  9,0,1,64'h90,  1,1,64'h10,1,0));
    vecs.push_back(dv(1,0,0,1,1,  8,0,1,64'h80,  1,2,64'h20,0,1));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,2,64'h20,1,0));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,3,64'h30,0,1));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,4,64'h40,0,2));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,8,64'h80,0,3));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    // forwarding: exec address result ignored, mem captured, commit bypass, exec data captured
    vecs.push_back(dv(1,0,0,0,1, 10,7,0,64'h0,   0,0,64'h0,0,4));
    vecs.push_back(bus(dv(1,0,0,0,0, 0,0,0,64'h0, 0,0,64'h0,0,3), 1, 7, 64'h77, 1));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,3));
    vecs.push_back(bus(dv(1,0,0,0,0, 0,0,0,64'h0, 0,0,64'h0,0,3), 2, 7, 64'h55, 0));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,10,64'h55,0,3));
    vecs.push_back(bus(dv(1,0,0,0,1, 11,2,0,64'h0, 0,0,64'h0,0,4), 0, 2, 64'h33, 0));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,11,64'h33,0,3));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,0,1, 12,4,0,64'h0,   0,0,64'h0,0,4));
    vecs.push_back(bus(dv(1,0,0,0,0, 0,0,0,64'h0, 0,0,64'h0,0,3), 1, 4, 64'h44, 0));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,12,64'h44,0,3));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    // flush with a pending write, then reset during an issue with a pending write
    vecs.push_back(dv(1,0,0,1,1,  1,0,1,64'h1,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,1,1,  2,0,1,64'h2,   1,1,64'h1,0,3));
    vecs.push_back(dv(1,0,0,1,1,  3,0,1,64'h3,   1,1,64'h1,0,2));
    vecs.push_back(dv(1,0,1,1,1,  4,0,1,64'h4,   1,1,64'h1,0,1));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,1,1,  1,0,1,64'h1,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,1,1,  2,0,1,64'h2,   1,1,64'h1,0,3));
    vecs.push_back(dv(1,0,0,1,1,  3,0,1,64'h3,   1,1,64'h1,0,2));
    vecs.push_back(dv(1,1,0,0,1,  4,0,1,64'h4,   1,1,64'h1,0,1));
    vecs.push_back(dv(1,0,0,0,1,  6,0,1,64'h6,   0,0,64'h0,0,4));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   1,6,64'h6,0,3));
    vecs.push_back(dv(1,0,0,0,0,  0,0,0,64'h0,   0,0,64'h0,0,4));

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n]);
      #2;
      if (vecs[n].chk) check_vec(vecs[n], n);
    end

    // three operands: op2 arrives on the memory bus, op3 later on the commit bus
    @(negedge clk);
    drive(dv(0,0,0,0,1, 14,0,1,64'h1, 0,0,64'h0,0,4));
    decodeROBTag2_i = 5'd3; decodeROBval2_i = '0;
    decodeROBTag3_i = 5'd4; decodeROBval3_i = '0;
    @(negedge clk);
    drive(bus(dv(0,0,0,0,0, 0,0,0,64'h0, 0,0,64'h0,0,0), 2, 3, 64'h3C, 0));
    #2;
    check("op3.wait1", 64'(ready_o), 64'd0);
    @(negedge clk);
    drive(bus(dv(0,0,0,0,0, 0,0,0,64'h0, 0,0,64'h0,0,0), 0, 4, 64'h4D, 0));
    #2;
    check("op3.wait2", 64'(ready_o), 64'd0);
    check("op3.free", 64'(freeCount_o), 64'd3);
    @(negedge clk);
    drive(dv(0,0,0,1,0, 0,0,0,64'h0, 0,0,64'h0,0,0));
    #2;
    check("op3.ready", 64'(ready_o), 64'd1);
    check("op3.tag", 64'(tag_o), 64'd14);
    check("op3.val1", val1_o, 64'h1);
    check("op3.val2", val2_o, 64'h3C);
    check("op3.val3", val3_o, 64'h4D);
    @(negedge clk);
    #2;
    check("op3.hold_tag", 64'(tag_o), 64'd14);
    check("op3.hold_free", 64'(freeCount_o), 64'd3);
    @(negedge clk);
    stall_i = 1'b0;
    #2;
    check("op3.issue_tag", 64'(tag_o), 64'd14);
    @(negedge clk);
    #2;
    check("op3.after_ready", 64'(ready_o), 64'd0);
    check("op3.after_free", 64'(freeCount_o), 64'd4);
    check("op3.after_val2", val2_o, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reservation_station_bank.md
Name: reservation_station_bank

Overview:
- Parametrised reservation-station bank holding NUM_ENTRIES instructions that wait for up to three operands.
- Sits between decode/rename and an execution unit.
- Captures operand results from three result buses: commit, execute and memory.
- Issues the oldest fully-ready entry each cycle using a true age matrix, not saturating ready-time counters.
- Supports flush on misprediction restore and reports its free-entry count to decode.

Parameters:
- NUM_ENTRIES, 4: number of entries (2..16).
- ROBsize, 16: reorder-buffer depth.
- ROBsizeLog, $clog2(ROBsize+1): tag width.
- DATA_W, 64: operand width. Bus and decode operands are DATA_W+1 bits; bit DATA_W is the valid bit.
- CMD_W, 10: command field width.
- CNT_W, $clog2(NUM_ENTRIES+1): free-count width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- needToRestore_i  in  1  flush all entries.
- decodeWriteEn_i  in  1  allocate request.
- decodeROBTag_i  in  ROBsizeLog  destination ROB tag.
- decodeROBTag1_i / decodeROBTag2_i / decodeROBTag3_i  in  ROBsizeLog  source tags.
- decodeROBval1_i / decodeROBval2_i / decodeROBval3_i  in  DATA_W+1  {valid, value}.
- decodeCommands_i  in  CMD_W  command.
- issueROBTagCom_i  in  ROBsizeLog  commit bus tag.
- issueROBvalCom_i  in  DATA_W+1  commit bus {valid, value}.
- issueROBTagExec_i  in  ROBsizeLog  execute bus tag.
- issueROBvalExec_i  in  DATA_W+1  execute bus {valid, value}.
- issueROBMemAccessExec_i  in  1  execute result is an address, not data.
- issueROBTagMem_i  in  ROBsizeLog  memory bus tag.
- issueROBvalMem_i  in  DATA_W+1  memory bus {valid, value}.
- stall_i  in  1  downstream cannot accept.
- stall_o  out  1  bank full.
- freeCount_o  out  CNT_W  number of non-busy entries.
- ready_o  out  1  some entry is ready.
- reservationStationVal1_o / reservationStationVal2_o / reservationStationVal3_o  out  DATA_W  issued operands.
- reservationStationCommands_o  out  CMD_W  issued command.
- reservationStationTag_o  out  ROBsizeLog  issued destination tag.

Behaviour:
- Reset / flush: reset_i or needToRestore_i clears every busy bit and the whole age matrix at the next edge. Reset has priority.
  - A decode write or issue in that cycle has no effect.
  - Outputs after reset: stall_o=0, ready_o=0, freeCount_o=NUM_ENTRIES, data outputs 0.
- Entry state: busy; per operand {valid, tag, value}; command; destination tag.
- Entry readiness: ready = busy & all three operand valids set.
- Allocation:
  - When decodeWriteEn_i & ~stall_o, the lowest-index non-busy entry is written at the edge.
  - decodeWriteEn_i while stall_o=1 is dropped; decode must hold the request.
  - An entry freed by issue in the same cycle is not reusable until the next cycle.
- Bus hits: a bus hits an operand when the bus valid bit is set and the bus tag equals the operand tag. The execute bus is ignored when issueROBMemAccessExec_i=1.
- Operand capture, per busy entry and each invalid operand, every cycle:
  - On a hit, latch the value and set valid.
  - Priority when several buses hit: Exec > Mem > Com. Values are identical by construction.
- Same-cycle bypass: an operand arriving invalid on a decode write whose tag hits a bus in that cycle is written already valid with the bus value.
- Age matrix:
  - older[i][j]=1 means entry i was allocated before entry j.
  - On allocation of entry k: older[k][*]=0, and older[j][k]=1 for every busy j≠k.
  - An issued entry's row and column are cleared.
- Issue selection: select the ready entry i with no ready entry j where older[j][i]=1. The result is one-hot or zero; ties are impossible.
- Issue outputs: combinational from the selected entry, and all zeros when nothing is selected.
  - ready_o = OR of all entry ready bits, independent of stall_i.
  - When ready_o & ~stall_i, the selected entry's busy bit clears at the edge.
  - stall_i=1 holds all entries; output contents may change only by capture, never by the selection moving to a younger entry.
- Status:
  - stall_o = all entries busy.
  - freeCount_o = popcount(~busy). Both are combinational from registers.
- Latency:
  - Entry written with all operands valid (or all bypassed): ready_o in the following cycle.
  - Bus hit at edge N: entry ready from cycle N+1.
- Rollover: none. The age matrix carries no counters to saturate or wrap.

Test Plan:
- Fill, NUM_ENTRIES=4: write 4 ready entries with tags 3,6,9,12 while stall_i=1 → stall_o=1, freeCount_o=0; fifth write dropped. Release stall → issue order 3,6,9,12 on consecutive cycles; freeCount_o returns to 4.
- Out-of-order wakeup: entry A (tag 5) waits on source tag 1; entry B (tag 6) is ready.
  - B issues first.
  - Commit bus tag 1, value 0xA0 → A issues next cycle with Val1=0xA0.
- Age vs index: free entry 0 after entries 1–3 are older and ready, reallocate entry 0 → entry 0 issues last.
- Forwarding rules:
  - Execute bus tag 7 with issueROBMemAccessExec_i=1 → operand stays invalid.
  - Same tag on the memory bus, value 0x55 → captured.
  - Decode write coinciding with commit bus tag 2, value 0x33 → operand bypassed; ready_o next cycle.
- Flush and reset: needToRestore_i with 3 busy entries while a write is requested → next cycle freeCount_o=4, ready_o=0. Reset asserted mid-issue gives the same result.
